// File: rtl/fpu_mmap_responder.sv
// fpu_mmap_responder
//   Memory-mapped register window that the FPU reads and the CPU writes.
//   FPU reads go through a three-state handshake (IDLE -> LOOKUP -> RESPOND).
//   The response is a registered one-cycle strobe that appears on the second
//   rising edge after the request is sampled in IDLE.
//   CPU stores update the register file on the next edge, in any state.
//   A store that hits the index being looked up is forwarded into the response.
//
// Optional feature: define FPU_MMAP_ERR_CNT_EN to build a saturating count of
//   bad FPU addresses. Without it, err_count is tied to 0.
//
// Ports
//   clk, rst_n            clock, async active-low reset
//   mapped_data_request   FPU read request (held until response)
//   mapped_address        FPU byte address
//   mapped_data           read data (0 unless mapped_data_valid)
//   mapped_data_valid     one-cycle response strobe
//   mapped_err            one-cycle bad-address flag, coincident with valid
//   err_count             count of bad FPU addresses
//   cpu_wr_en/addr/data   CPU store port
module fpu_mmap_responder #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_1000,
  parameter int          NUM_REGS  = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mapped_data_request,
  input  logic [31:0] mapped_address,
  output logic [31:0] mapped_data,
  output logic        mapped_data_valid,
  input  logic        cpu_wr_en,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wr_data,
  output logic        mapped_err,
  output logic [7:0]  err_count
);

  localparam int          IW   = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [32:0] SPAN = 33'(4 * NUM_REGS);

  typedef enum logic [1:0] {IDLE, LOOKUP, RESPOND} state_t;

  state_t state, state_nxt;
  logic   latch_en, lookup_en, respond_en;

  logic [NUM_REGS-1:0][31:0] regs;
  logic [31:0]               addr_q;
  logic [31:0]               look_data;
  logic                      look_err;

  // Returns {bad, index}. The subtraction is done 33 bits wide, so an
  // address below the base wraps to a huge offset and fails the span test.
  function automatic logic [IW:0] decode(input logic [31:0] a);
    logic [32:0] off;
    logic [IW:0] r;
    off       = {1'b0, a} - {1'b0, BASE_ADDR};
    r[IW]     = (off >= SPAN) | (a[1:0] != 2'b00);
    r[IW-1:0] = off[IW+1:2];
    return r;
  endfunction

  logic [IW:0] cw, rd;
  assign cw = decode(cpu_addr);
  assign rd = decode(addr_q);

  logic cpu_hit;
  assign cpu_hit = cpu_wr_en & ~cw[IW];

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // next state and per-state strobes
  always_comb begin
    state_nxt  = state;
    latch_en   = 1'b0;
    lookup_en  = 1'b0;
    respond_en = 1'b0;
    case (state)
      IDLE: if (mapped_data_request) begin
        latch_en  = 1'b1;
        state_nxt = LOOKUP;
      end
      LOOKUP: begin
        lookup_en = 1'b1;
        state_nxt = RESPOND;
      end
      RESPOND: begin
        respond_en = 1'b1;
        state_nxt  = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // register file
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) regs <= '0;
    else if (cpu_hit) regs[cw[IW-1:0]] <= cpu_wr_data;
  end

  // request latch and lookup; a same-index store in LOOKUP wins (write-first)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q    <= '0;
      look_data <= '0;
      look_err  <= 1'b0;
    end else begin
      if (latch_en) addr_q <= mapped_address;
      if (lookup_en) begin
        look_err <= rd[IW];
        if (rd[IW])
          look_data <= '0;
        else if (cpu_hit && cw[IW-1:0] == rd[IW-1:0])
          look_data <= cpu_wr_data;
        else
          look_data <= regs[rd[IW-1:0]];
      end
    end
  end

  // Output stage is loaded while leaving RESPOND. A store made during
  // RESPOND cannot reach look_data, so the captured response is kept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mapped_data_valid <= 1'b0;
      mapped_data       <= '0;
      mapped_err        <= 1'b0;
    end else begin
      mapped_data_valid <= respond_en;
      mapped_data       <= respond_en ? look_data : 32'h0;
      mapped_err        <= respond_en & look_err;
    end
  end

`ifdef FPU_MMAP_ERR_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                              err_count <= 8'h00;
    else if (mapped_err && err_count != 8'hFF) err_count <= err_count + 8'h01;
  end
`else
  assign err_count = 8'h00;
`endif

endmodule

// File: doc/fpu_mmap_responder.md
FPU_MMAP_RESPONDER -- requirements
Module: fpu_mmap_responder

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h0000_1000, byte address of register 0 in the mapped window.
REQ-002 SHALL have parameter NUM_REGS, default 16, number of 32-bit mapped registers (power of two, 2..64).
REQ-003 SHALL have port clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port mapped_data_request  input  1  FPU read request, held high until a response is returned.
REQ-006 SHALL have port mapped_address  input  32  FPU byte address, stable while the request is high.
REQ-007 SHALL have port mapped_data  output  32  read data, meaningful only while mapped_data_valid is high.
REQ-008 SHALL have port mapped_data_valid  output  1  one-cycle response strobe.
REQ-009 SHALL have port cpu_wr_en  input  1  CPU store strobe into the window.
REQ-010 SHALL have port cpu_addr  input  32  CPU byte address.
REQ-011 SHALL have port cpu_wr_data  input  32  CPU store data.
REQ-012 SHALL have port mapped_err  output  1  one-cycle strobe, coincident with valid, flagging a bad FPU address.
REQ-013 SHALL have port err_count  output  8  count of bad FPU addresses.

Function
REQ-014 SHALL implement the FSM states IDLE, LOOKUP and RESPOND.
REQ-015 In IDLE with mapped_data_request high, SHALL latch mapped_address and go to LOOKUP.
REQ-016 In LOOKUP, SHALL register the read data and the error flag, then go to RESPOND.
REQ-017 In RESPOND, SHALL drive mapped_data_valid high for exactly one cycle, then return to IDLE.
REQ-018 Latency SHALL be fixed: valid asserts on the second rising edge after the edge that samples the request in IDLE.
REQ-019 The requester SHALL drop the request in the cycle valid is high; a request still high when IDLE is re-entered SHALL be served as a new request.
REQ-020 Index SHALL equal (address - BASE_ADDR) >> 2.
REQ-021 An address is bad if it is below BASE_ADDR, at or above BASE_ADDR + 4*NUM_REGS, or has bits [1:0] nonzero.
REQ-022 A bad FPU address SHALL return mapped_data = 0 with mapped_err high.
REQ-023 A CPU write SHALL update the register on the next edge, from any FSM state; a bad CPU address SHALL be silently ignored.
REQ-024 A CPU write in the LOOKUP cycle to the index being looked up SHALL be forwarded: the response carries the new data (write-first).
REQ-025 A CPU write in RESPOND SHALL NOT alter the response already captured.
REQ-026 mapped_data SHALL be 0 whenever mapped_data_valid is low.

Reset
REQ-027 rst_n low SHALL asynchronously set the FSM to IDLE and clear all registers, mapped_data, mapped_data_valid, mapped_err and err_count.
REQ-028 A reset during LOOKUP or RESPOND SHALL abort the transaction with no valid strobe; the requester must re-issue the request.

Configuration
REQ-029 Macro FPU_MMAP_ERR_CNT_EN defined: err_count SHALL increment on each mapped_err strobe, saturating at 8'hFF, cleared only by reset.
REQ-030 Macro FPU_MMAP_ERR_CNT_EN undefined: err_count SHALL be constant 0 and the counter logic SHALL be absent. mapped_err behaves identically in both builds.

Verification
REQ-031 CPU writes 32'hDEAD_BEEF to 0x1008; FPU requests 0x1008 -> valid exactly 2 cycles after the request is sampled, data 32'hDEAD_BEEF, mapped_err 0.
REQ-032 FPU requests 0x1040 (NUM_REGS=16) and 0x1002 -> each returns data 0 with mapped_err high; with the macro defined, err_count reaches 2.
REQ-033 FPU requests 0x1004 (holds 32'h1); CPU writes 32'h55 to 0x1004 in the LOOKUP cycle -> response 32'h55; the same write in RESPOND -> response 32'h1, and a later read returns 32'h55.
REQ-034 Request held high for 6 cycles -> two valid strobes, each one cycle wide, separated by IDLE.
REQ-035 rst_n pulsed low during LOOKUP -> no valid strobe, FSM in IDLE, all registers read 0 afterwards.
REQ-036 Macro defined, 300 bad requests -> err_count holds 8'hFF; macro undefined -> err_count stays 0.
